// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the divider sequencing controller: op-bit positions and FSM states.
package div_seq_ctrl_pkg;

    // req_op_i = {word, rem, unsigned}
    localparam int DIVOP_W    = 3;
    localparam int DIVOP_WORD = 2;
    localparam int DIVOP_REM  = 1;
    localparam int DIVOP_UNS  = 0;

    typedef enum logic [2:0] {
        DIV_IDLE  = 3'd0,
        DIV_START = 3'd1,
        DIV_BUSY  = 3'd2,
        DIV_DONE  = 3'd3,
        DIV_DRAIN = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// EX-side request/response handshake of the divider controller; names are from the controller's view.
interface div_seq_ctrl_if
    import div_seq_ctrl_pkg::*;
#(
    parameter int XLEN = 64
);
    logic               req_valid_i;
    logic               req_ready_o;
    logic [DIVOP_W-1:0] req_op_i;
    logic [XLEN-1:0]    req_a_i;
    logic [XLEN-1:0]    req_b_i;
    logic               flush_i;
    logic               resp_valid_o;
    logic               resp_ready_i;
    logic [XLEN-1:0]    resp_data_o;
    logic               stall_o;

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, flush_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_data_o, stall_o
    );

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, flush_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_data_o, stall_o
    );
endinterface

// File: rtl/div_seq_ctrl_operand_prep.sv
// Combinational operand conditioning: W-op extension plus divide-by-zero and signed-overflow detection.
module div_operand_prep
    import div_seq_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [DIVOP_W-1:0] i_op,
    input  logic [XLEN-1:0]    i_a,
    input  logic [XLEN-1:0]    i_b,
    output logic [XLEN-1:0]    o_a,
    output logic [XLEN-1:0]    o_b,
    output logic               o_zero,
    output logic               o_ovf
);
    // Most negative value at full width, and the 32-bit one as it looks after sign extension
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

    logic            w_word;
    logic            w_uns;
    logic [XLEN-1:0] w_min;

    assign w_word = i_op[DIVOP_WORD];
    assign w_uns  = i_op[DIVOP_UNS];
    assign w_min  = w_word ? MIN_W : MIN_X;

    always_comb begin
        o_a = i_a;
        o_b = i_b;
        if (w_word) begin
            o_a = w_uns ? {{(XLEN-32){1'b0}}, i_a[31:0]} : {{(XLEN-32){i_a[31]}}, i_a[31:0]};
            o_b = w_uns ? {{(XLEN-32){1'b0}}, i_b[31:0]} : {{(XLEN-32){i_b[31]}}, i_b[31:0]};
        end
    end

    assign o_zero = (o_b == '0);
    assign o_ovf  = ~w_uns & (o_a == w_min) & (o_b == '1);
endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer in front of the shared SRT4 divider: accepts one EX request, short-circuits
// special cases, starts the core, and holds the result until EX takes it.
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 80
) (
    input  logic            clock,
    input  logic            reset,
    div_seq_ctrl_if.slave   ex,
    output logic            core_start_o,
    output logic            core_signed_o,
    output logic [XLEN-1:0] core_a_o,
    output logic [XLEN-1:0] core_b_o,
    input  logic            core_done_i,
    input  logic [XLEN-1:0] core_q_i,
    input  logic [XLEN-1:0] core_r_i,
    output logic            timeout_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    div_state_e      r_state;
    logic [XLEN-1:0] r_a, r_b, r_data;
    logic            r_word, r_rem, r_uns;
    logic            r_start, r_valid, r_tmo;
    logic [CW-1:0]   r_cnt;

    logic [XLEN-1:0] w_a, w_b, w_spec_res, w_core_res;
    logic            w_zero, w_ovf, w_idle, w_accept, w_tmo_hit, w_busy;

    div_operand_prep #(.XLEN(XLEN)) u_prep (
        .i_op  (ex.req_op_i),
        .i_a   (ex.req_a_i),
        .i_b   (ex.req_b_i),
        .o_a   (w_a),
        .o_b   (w_b),
        .o_zero(w_zero),
        .o_ovf (w_ovf)
    );

    function automatic logic [XLEN-1:0] fix_w(input logic word, input logic [XLEN-1:0] x);
        return word ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
    endfunction

    assign w_idle     = (r_state == DIV_IDLE);
    assign w_accept   = ex.req_valid_i & w_idle & ~ex.flush_i;
    // >= so a flush landing on the last BUSY cycle still lets DRAIN time out
    assign w_tmo_hit  = (r_cnt >= CW'(TIMEOUT - 1));
    assign w_core_res = r_rem ? core_r_i : core_q_i;
    assign w_spec_res = w_zero ? (ex.req_op_i[DIVOP_REM] ? w_a : '1)
                               : (ex.req_op_i[DIVOP_REM] ? '0 : w_a);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= DIV_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_data  <= '0;
            r_word  <= 1'b0;
            r_rem   <= 1'b0;
            r_uns   <= 1'b0;
            r_start <= 1'b0;
            r_valid <= 1'b0;
            r_tmo   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                DIV_IDLE: if (w_accept) begin
                    r_a    <= w_a;
                    r_b    <= w_b;
                    r_word <= ex.req_op_i[DIVOP_WORD];
                    r_rem  <= ex.req_op_i[DIVOP_REM];
                    r_uns  <= ex.req_op_i[DIVOP_UNS];
                    if (w_zero | w_ovf) begin
                        r_data  <= fix_w(ex.req_op_i[DIVOP_WORD], w_spec_res);
                        r_valid <= 1'b1;
                        r_state <= DIV_DONE;
                    end else begin
                        r_start <= 1'b1;
                        r_state <= DIV_START;
                    end
                end
                DIV_START: begin
                    r_cnt   <= '0;
                    r_state <= ex.flush_i ? DIV_IDLE : DIV_BUSY;
                end
                DIV_BUSY: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (ex.flush_i) begin
                        r_state <= core_done_i ? DIV_IDLE : DIV_DRAIN;
                    end else if (core_done_i) begin
                        r_data  <= fix_w(r_word, w_core_res);
                        r_valid <= 1'b1;
                        r_state <= DIV_DONE;
                    end else if (w_tmo_hit) begin
                        r_tmo   <= 1'b1;
                        r_data  <= '0;
                        r_valid <= 1'b1;
                        r_state <= DIV_DONE;
                    end
                end
                DIV_DRAIN: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (core_done_i | w_tmo_hit) begin
                        if (!core_done_i) r_tmo <= 1'b1;
                        r_state <= DIV_IDLE;
                    end
                end
                DIV_DONE: if (ex.resp_ready_i | ex.flush_i) begin
                    r_valid <= 1'b0;
                    r_state <= DIV_IDLE;
                end
                default: r_state <= DIV_IDLE;
            endcase
        end
    end

    assign w_busy = (r_state == DIV_START) | (r_state == DIV_BUSY) | (r_state == DIV_DRAIN);

    assign ex.req_ready_o  = w_idle;
    assign ex.resp_valid_o = r_valid;
    assign ex.resp_data_o  = r_data;
    assign ex.stall_o      = (ex.req_valid_i & ~w_idle) | w_busy
                           | ((r_state == DIV_DONE) & ~ex.resp_ready_i);

    // A flush during START must keep the core from ever seeing the pulse
    assign core_start_o  = r_start & ~ex.flush_i;
    assign core_signed_o = ~r_uns;
    assign core_a_o      = r_a;
    assign core_b_o      = r_b;
    assign timeout_o     = r_tmo;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: vector table for single requests plus hand sequences
// for back-pressure, flushes, reset and timeout, against a behavioural divider core.
module tb_div_seq_ctrl;
    import div_seq_ctrl_pkg::*;

    localparam int XLEN     = 64;
    localparam int TIMEOUT  = 80;
    localparam int CORE_LAT = 33;

    logic            clock = 1'b0;
    logic            reset;
    logic            core_start_o, core_signed_o, core_done_i, timeout_o;
    logic [XLEN-1:0] core_a_o, core_b_o, core_q_i, core_r_i;

    always #5 clock = ~clock;

    div_seq_ctrl_if #(.XLEN(XLEN)) ex_if ();

    div_seq_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clock        (clock),
        .reset        (reset),
        .ex           (ex_if.slave),
        .core_start_o (core_start_o),
        .core_signed_o(core_signed_o),
        .core_a_o     (core_a_o),
        .core_b_o     (core_b_o),
        .core_done_i  (core_done_i),
        .core_q_i     (core_q_i),
        .core_r_i     (core_r_i),
        .timeout_o    (timeout_o)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_starts = 0;
    bit core_hang = 1'b0;
    bit core_act;
    int core_cnt;
    logic signed [XLEN-1:0] sa, sb;

    // Core model: done pulses CORE_LAT cycles after the cycle in which it samples start
    initial begin
        core_done_i = 1'b0; core_q_i = '0; core_r_i = '0; core_act = 1'b0; core_cnt = 0;
        forever begin
            @(negedge clock);
            core_done_i = 1'b0;
            if (reset) core_act = 1'b0;
            else begin
                if (core_act) begin
                    core_cnt--;
                    if (core_cnt == 0) begin core_done_i = 1'b1; core_act = 1'b0; end
                end
                if (core_start_o) begin
                    n_starts++;
                    core_act = !core_hang;
                    core_cnt = CORE_LAT + 1;
                    if (core_signed_o) begin
                        sa = $signed(core_a_o); sb = $signed(core_b_o);
                        core_q_i = sa / sb; core_r_i = sa % sb;
                    end else begin
                        core_q_i = core_a_o / core_b_o; core_r_i = core_a_o % core_b_o;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Waits (bounded) for resp_valid; lat counts cycles from the accept cycle
    task automatic wait_resp(output int lat);
        lat = 1;
        @(negedge clock);
        while (!ex_if.resp_valid_o && lat < 300) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic run_req(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           output logic [XLEN-1:0] data, output int lat, output int starts);
        int s0;
        cyc();
        s0 = n_starts;
        ex_if.req_valid_i = 1'b1; ex_if.req_op_i = op; ex_if.req_a_i = a; ex_if.req_b_i = b;
        ex_if.resp_ready_i = 1'b1;
        cyc();
        ex_if.req_valid_i = 1'b0;
        wait_resp(lat);
        data   = ex_if.resp_data_o;
        starts = n_starts - s0;
    endtask

    typedef struct {
        logic [2:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        int              lat;
        int              starts;
        string           name;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [XLEN-1:0] d;
        int lat, st, s0, c;
        bit saw_v;

        // op = {word, rem, unsigned}
        vecs[0] = '{3'b000, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 36, 1, "div_20_m3"};
        vecs[1] = '{3'b010, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 36, 1, "rem_20_m3"};
        vecs[2] = '{3'b011, 64'h1234, 64'd0, 64'h1234, 1, 0, "remu_by0"};
        vecs[3] = '{3'b001, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, "divu_by0"};
        vecs[4] = '{3'b100, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0, "divw_ovf"};
        vecs[5] = '{3'b110, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0, "remw_ovf"};
        vecs[6] = '{3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 0, "div_ovf64"};
        vecs[7] = '{3'b101, 64'h1234_5678_FFFF_FFF0, 64'd2, 64'h7FFF_FFF8, 36, 1, "divuw"};
        vecs[8] = '{3'b100, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 36, 1, "divw_m7_2"};
        vecs[9] = '{3'b111, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0001, 1, 0, "remuw_by0"};

        reset = 1'b1;
        ex_if.req_valid_i = 1'b0; ex_if.req_op_i = '0; ex_if.req_a_i = '0; ex_if.req_b_i = '0;
        ex_if.flush_i = 1'b0; ex_if.resp_ready_i = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_resp_valid", ex_if.resp_valid_o, 0);
        chk("rst_resp_data", ex_if.resp_data_o, 0);
        chk("rst_core_start", core_start_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_req_ready", ex_if.req_ready_o, 1);

        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i].op, vecs[i].a, vecs[i].b, d, lat, st);
            chk({vecs[i].name, "_data"}, d, vecs[i].exp);
            chk({vecs[i].name, "_lat"}, XLEN'(lat), XLEN'(vecs[i].lat));
            chk({vecs[i].name, "_starts"}, XLEN'(st), XLEN'(vecs[i].starts));
        end

        // DIVU 100/7 with EX holding off the response for 5 cycles
        cyc();
        ex_if.req_valid_i = 1'b1; ex_if.req_op_i = 3'b001; ex_if.req_a_i = 64'd100; ex_if.req_b_i = 64'd7;
        ex_if.resp_ready_i = 1'b0;
        @(negedge clock);
        chk("bp_ready_idle", ex_if.req_ready_o, 1);
        cyc();
        ex_if.req_valid_i = 1'b0;
        @(negedge clock);
        chk("bp_ready_start", ex_if.req_ready_o, 0);
        cyc();
        wait_resp(lat);
        chk("bp_lat", XLEN'(lat + 1), 64'd36);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_data", ex_if.resp_data_o, 64'd14);
            chk("bp_hold_stall", ex_if.stall_o, 1);
            cyc();
            @(negedge clock);
        end
        chk("bp_ready_done", ex_if.req_ready_o, 0);
        cyc();
        ex_if.resp_ready_i = 1'b1;
        @(negedge clock);
        chk("bp_stall_release", ex_if.stall_o, 0);
        cyc();
        @(negedge clock);
        chk("bp_valid_drop", ex_if.resp_valid_o, 0);
        chk("bp_ready_back", ex_if.req_ready_o, 1);

        // Flush 10 cycles into BUSY, second request queued immediately behind it
        cyc();
        s0 = n_starts;
        ex_if.req_valid_i = 1'b1; ex_if.req_op_i = 3'b001; ex_if.req_a_i = 64'd1000; ex_if.req_b_i = 64'd10;
        cyc();
        ex_if.req_valid_i = 1'b0;
        repeat (10) cyc();
        ex_if.flush_i = 1'b1;
        cyc();
        ex_if.flush_i = 1'b0;
        ex_if.req_valid_i = 1'b1; ex_if.req_op_i = 3'b000;
        ex_if.req_a_i = 64'hFFFF_FFFF_FFFF_FF9C; ex_if.req_b_i = 64'd7;
        c = 12; saw_v = 1'b0;
        @(negedge clock);
        while (!ex_if.req_ready_o && c < 300) begin
            if (ex_if.resp_valid_o) saw_v = 1'b1;
            cyc();
            c++;
            @(negedge clock);
        end
        chk("drain_ready_cycle", XLEN'(c), 64'd36);
        chk("drain_no_resp", XLEN'(saw_v), 0);
        chk("drain_starts", XLEN'(n_starts - s0), 1);
        cyc();
        ex_if.req_valid_i = 1'b0;
        wait_resp(lat);
        chk("drain_second_lat", XLEN'(lat), 64'd36);
        chk("drain_second_data", ex_if.resp_data_o, 64'hFFFF_FFFF_FFFF_FFF2);
        chk("drain_total_starts", XLEN'(n_starts - s0), 2);

        // Flush during START suppresses the pulse
        cyc();
        s0 = n_starts;
        ex_if.req_valid_i = 1'b1; ex_if.req_op_i = 3'b001; ex_if.req_a_i = 64'd9; ex_if.req_b_i = 64'd3;
        cyc();
        ex_if.req_valid_i = 1'b0;
        ex_if.flush_i = 1'b1;
        @(negedge clock);
        chk("fstart_no_pulse", core_start_o, 0);
        cyc();
        ex_if.flush_i = 1'b0;
        @(negedge clock);
        chk("fstart_idle", ex_if.req_ready_o, 1);
        chk("fstart_starts", XLEN'(n_starts - s0), 0);

        // Flush in DONE drops the response
        cyc();
        ex_if.req_valid_i = 1'b1; ex_if.req_op_i = 3'b001; ex_if.req_a_i = 64'd5; ex_if.req_b_i = 64'd0;
        ex_if.resp_ready_i = 1'b0;
        cyc();
        ex_if.req_valid_i = 1'b0;
        @(negedge clock);
        chk("fdone_valid", ex_if.resp_valid_o, 1);
        cyc();
        ex_if.flush_i = 1'b1;
        cyc();
        ex_if.flush_i = 1'b0;
        @(negedge clock);
        chk("fdone_dropped", ex_if.resp_valid_o, 0);
        chk("fdone_idle", ex_if.req_ready_o, 1);
        ex_if.resp_ready_i = 1'b1;

        // Reset in the middle of BUSY
        cyc();
        ex_if.req_valid_i = 1'b1; ex_if.req_op_i = 3'b000; ex_if.req_a_i = 64'd20;
        ex_if.req_b_i = 64'hFFFF_FFFF_FFFF_FFFD;
        cyc();
        ex_if.req_valid_i = 1'b0;
        repeat (10) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clock);
        chk("mrst_resp_valid", ex_if.resp_valid_o, 0);
        chk("mrst_resp_data", ex_if.resp_data_o, 0);
        chk("mrst_core_start", core_start_o, 0);
        chk("mrst_timeout", timeout_o, 0);
        chk("mrst_idle", ex_if.req_ready_o, 1);
        chk("mrst_stall", ex_if.stall_o, 0);

        // Core that never finishes: START cycle, then TIMEOUT BUSY cycles, then the error
        core_hang = 1'b1;
        cyc();
        ex_if.req_valid_i = 1'b1; ex_if.req_op_i = 3'b001; ex_if.req_a_i = 64'd50; ex_if.req_b_i = 64'd5;
        ex_if.resp_ready_i = 1'b0;
        cyc();
        ex_if.req_valid_i = 1'b0;
        c = 1;
        @(negedge clock);
        while (!timeout_o && c < 300) begin
            cyc();
            c++;
            @(negedge clock);
        end
        chk("tmo_cycle", XLEN'(c), XLEN'(TIMEOUT + 2));
        chk("tmo_resp_valid", ex_if.resp_valid_o, 1);
        chk("tmo_resp_data", ex_if.resp_data_o, 0);
        cyc();
        ex_if.resp_ready_i = 1'b1;
        cyc();
        @(negedge clock);
        chk("tmo_sticky", timeout_o, 1);
        chk("tmo_consumed", ex_if.resp_valid_o, 0);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        core_hang = 1'b0;
        @(negedge clock);
        chk("tmo_cleared", timeout_o, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
